// File: rtl/alu_result_collector.sv
// alu_result_collector: arbitrates ALU unit results into a tagged FIFO with valid/ready output and drop statistics
module alu_result_collector #(
  parameter int width = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width-1:0]         Arith_OUT,
  input  logic                     Arith_Flag,
  input  logic [width-1:0]         Logic_OUT,
  input  logic                     Logic_Flag,
  input  logic [width-1:0]         CMP_OUT,
  input  logic                     CMP_Flag,
  input  logic [width-1:0]         Shift_OUT,
  input  logic                     Shift_Flag,
  input  logic                     Res_Ready,
  output logic                     Res_Valid,
  output logic [width-1:0]         Res_OUT,
  output logic [1:0]               Res_Src,
  output logic [$clog2(DEPTH):0]   Fifo_Count,
  output logic                     Overflow,
  output logic                     Collision,
  output logic [CNT_W-1:0]         Drop_Count
);
  localparam int AW = $clog2(DEPTH);

  logic [width+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_count;
  logic             r_ov, r_col;
  logic [CNT_W-1:0] r_drop;

  logic             w_push, w_pop, w_accept, w_full_drop;
  logic [2:0]       w_nflags, w_drops;
  logic [width+1:0] w_entry;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_next;
  logic [AW:0]      w_count_next;

  assign w_push      = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
  assign w_nflags    = {2'b0, Arith_Flag} + {2'b0, Logic_Flag} + {2'b0, CMP_Flag} + {2'b0, Shift_Flag};
  assign w_entry     = Arith_Flag ? {2'd0, Arith_OUT} :
                       Logic_Flag ? {2'd1, Logic_OUT} :
                       CMP_Flag   ? {2'd2, CMP_OUT}   : {2'd3, Shift_OUT};
  assign w_pop       = Res_Valid & Res_Ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_accept    = w_push & ((r_count < (AW+1)'(DEPTH)) | w_pop);
  assign w_full_drop = w_push & ~w_accept;
  assign w_drops     = (w_push ? w_nflags - 3'd1 : 3'd0) + {2'b0, w_full_drop};
  assign w_drop_sum  = {1'b0, r_drop} + (CNT_W+1)'(w_drops);
  assign w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
  assign w_count_next = (w_accept & ~w_pop) ? r_count + 1'b1 :
                        (~w_accept & w_pop) ? r_count - 1'b1 : r_count;

  assign Res_Valid  = r_count != '0;
  assign Res_Src    = r_mem[r_rp][width+1:width];
  assign Res_OUT    = r_mem[r_rp][width-1:0];
  assign Fifo_Count = r_count;
  assign Overflow   = r_ov;
  assign Collision  = r_col;
  assign Drop_Count = r_drop;

  // FIFO storage, pointers, occupancy and sticky status; storage is cleared so outputs read 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ov    <= 1'b0;
      r_col   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wp] <= w_entry;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= w_count_next;
      r_ov    <= r_ov | w_full_drop;
      r_col   <= r_col | (w_nflags > 3'd1);
      r_drop  <= w_drop_next;
    end
  end
endmodule
